// File: rtl/bram_pkg.sv
// Shared types and the lane-merge helper for the simple-dual-port RAM kernel.
package bram_pkg;

  typedef enum logic {BRAM_INIT, BRAM_READY} bram_state_e;

  // lane_merge works on a fixed widest word; callers widen/truncate around it
  localparam int BRAM_MAX_DATA_W = 256;
  localparam int BRAM_LANE_IDX_W = 8;

  function automatic logic [BRAM_MAX_DATA_W-1:0] lane_merge(
    input logic [BRAM_MAX_DATA_W-1:0] old_word,
    input logic [BRAM_MAX_DATA_W-1:0] new_word,
    input logic [BRAM_MAX_DATA_W-1:0] lane_en,
    input int unsigned                lane_width
  );
    logic [BRAM_MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < BRAM_MAX_DATA_W; b++) begin
      if (lane_en[BRAM_LANE_IDX_W'(b / lane_width)]) merged[b] = new_word[b];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_init_seq.sv
// Post-reset zero-fill sequencer: walks every address once, then parks in READY.
module bram_init_seq
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic                  init_done
);

  bram_state_e           state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BRAM_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Leave INIT on the last address rather than on counter wrap
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    init_we    = 1'b0;
    case (state)
      BRAM_INIT: begin
        init_we = 1'b1;
        if (cnt == {ADDR_WIDTH{1'b1}}) state_next = BRAM_READY;
        else                           cnt_next   = cnt + ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

  assign init_addr = cnt;
  assign init_done = (state == BRAM_READY);

endmodule

// File: rtl/bram_sdp_kernel.sv
// Simple-dual-port RAM with lane write enables, 1- or 2-cycle read latency and zero-fill on reset.
// Macro BRAM_SDP_BYPASS_EN selects write-first collision behaviour (default read-first).
module bram_sdp_kernel
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LANE_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_LANES-1:0]  wr_lane_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
      $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
      $error("RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH > BRAM_MAX_DATA_W) begin : g_bad_width
      $error("DATA_WIDTH exceeds lane_merge capacity");
    end
  endgenerate

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_LANES-1:0]  lane_en
  );
    logic [BRAM_MAX_DATA_W-1:0] wide;
    wide = lane_merge(BRAM_MAX_DATA_W'(old_word), BRAM_MAX_DATA_W'(new_word),
                      BRAM_MAX_DATA_W'(lane_en), LANE_WIDTH);
    return wide[DATA_WIDTH-1:0];
  endfunction

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  bram_init_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_done (init_done)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_fire, rd_fire, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] wr_word, rd_word;

  // User ports are ignored until the zero-fill has finished
  assign wr_fire  = init_done & wr_en;
  assign rd_fire  = init_done & rd_en;
  assign mem_we   = init_we | wr_fire;
  assign mem_addr = init_done ? wr_addr : init_addr;
  assign wr_word  = init_done ? merge_word(mem[wr_addr], wr_data, wr_lane_en) : '0;

`ifdef BRAM_SDP_BYPASS_EN
  assign rd_word = (wr_fire && (wr_addr == rd_addr)) ?
                   merge_word(mem[rd_addr], wr_data, wr_lane_en) : mem[rd_addr];
`else
  assign rd_word = mem[rd_addr];
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= wr_word;
  end

  // Stage p0: array read register
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] rd_data_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      rd_data_p0 <= '0;
    end else begin
      vld_p0 <= rd_fire;
      if (rd_fire) rd_data_p0 <= rd_word;
    end
  end

  // Stage p1: optional output register
  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  vld_p1;
      logic [DATA_WIDTH-1:0] rd_data_p1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1     <= 1'b0;
          rd_data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) rd_data_p1 <= rd_data_p0;
        end
      end

      assign rd_valid = vld_p1;
      assign rd_data  = rd_data_p1;
    end else begin : g_lat1
      assign rd_valid = vld_p0;
      assign rd_data  = rd_data_p0;
    end
  endgenerate

endmodule

// File: tb/tb_bram_sdp_kernel.sv
// Bench for bram_sdp_kernel: latency-1 and latency-2 instances driven in lockstep, queue scoreboard.
module tb_bram_sdp_kernel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [1:0]  wr_lane_en = '0;
  logic [15:0] wr_data = '0;

  logic        init_done1, init_done2, rd_valid1, rd_valid2;
  logic [15:0] rd_data1, rd_data2;

  always #5 clk = ~clk;

  bram_sdp_kernel #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .init_done(init_done1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_en(wr_lane_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1));

  bram_sdp_kernel #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .init_done(init_done2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_en(wr_lane_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2));

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [1:0]  le;
    logic [15:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic [15:0] exp;
  } vec_t;

  exp_t        q1[$], q2[$];
  int          errors = 0, checks = 0, cyc = 0;
  logic [15:0] model_mem [16];
  logic        model_ready = 1'b0;
  int          model_cnt = 0;

`ifdef BRAM_SDP_BYPASS_EN
  localparam logic [15:0] E_COL0 = 16'hAAAA, E_COL1 = 16'h1111, E_COL2 = 16'h11AA;
  localparam bit BYPASS = 1'b1;
`else
  localparam logic [15:0] E_COL0 = 16'h1111, E_COL1 = 16'hAAAA, E_COL2 = 16'h1111;
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] le);
    logic [15:0] r;
    r[7:0]  = le[0] ? new_w[7:0]  : old_w[7:0];
    r[15:8] = le[1] ? new_w[15:8] : old_w[15:8];
    return r;
  endfunction

  // One clock: drive inputs, take the edge, update the reference model.
  task automatic do_cycle(input logic we, input logic [3:0] wa, input logic [1:0] le,
                          input logic [15:0] wd, input logic re, input logic [3:0] ra,
                          input logic use_exp, input logic [15:0] exp);
    logic [15:0] pred;
    exp_t e;
    wr_en = we; wr_addr = wa; wr_lane_en = le; wr_data = wd;
    rd_en = re; rd_addr = ra;
    @(posedge clk);
    cyc++;
    if (model_ready) begin
      if (re) begin
        pred = model_mem[ra];
        if (BYPASS && we && wa == ra) pred = merge(model_mem[ra], wd, le);
        e.data = use_exp ? exp : pred;
        e.due = cyc;     q1.push_back(e);
        e.due = cyc + 1; q2.push_back(e);
      end
      if (we) model_mem[wa] = merge(model_mem[wa], wd, le);
    end else begin
      model_cnt++;
      if (model_cnt == 16) begin
        model_ready = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
      end
    end
    #1;
    check("init_done_lat1", {15'd0, init_done1}, {15'd0, model_ready});
    check("init_done_lat2", {15'd0, init_done2}, {15'd0, model_ready});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic reset_dut();
    wr_en = 0; rd_en = 0;
    rst_n = 1'b0;
    #1;
    check("rst_valid_lat1", {15'd0, rd_valid1}, 16'd0);
    check("rst_valid_lat2", {15'd0, rd_valid2}, 16'd0);
    check("rst_data_lat1", rd_data1, 16'd0);
    check("rst_data_lat2", rd_data2, 16'd0);
    check("rst_init_done", {14'd0, init_done1, init_done2}, 16'd0);
    q1.delete(); q2.delete();
    model_ready = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rd_valid1) begin
      if (!init_done1) check("valid_during_init_lat1", 16'd1, 16'd0);
      if (q1.size() == 0) check("unexpected_valid_lat1", rd_data1, 16'hxxxx);
      else begin
        exp_t e;
        e = q1.pop_front();
        check("rd_data_lat1", rd_data1, e.data);
        check("rd_due_lat1", 16'(cyc), 16'(e.due));
      end
    end else if (q1.size() > 0 && q1[0].due <= cyc) begin
      check("missing_valid_lat1", 16'd0, 16'd1);
      void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rd_valid2) begin
      if (!init_done2) check("valid_during_init_lat2", 16'd1, 16'd0);
      if (q2.size() == 0) check("unexpected_valid_lat2", rd_data2, 16'hxxxx);
      else begin
        exp_t e;
        e = q2.pop_front();
        check("rd_data_lat2", rd_data2, e.data);
        check("rd_due_lat2", 16'(cyc), 16'(e.due));
      end
    end else if (q2.size() > 0 && q2[0].due <= cyc) begin
      check("missing_valid_lat2", 16'd0, 16'd1);
      void'(q2.pop_front());
    end
  end

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1, 4'd3,  2'b11, 16'hBEEF, 0, 4'd0,  16'h0000};
    tbl[1]  = '{1, 4'd3,  2'b10, 16'h12AB, 0, 4'd0,  16'h0000};
    tbl[2]  = '{0, 4'd0,  2'b00, 16'h0000, 1, 4'd3,  16'h12EF};
    tbl[3]  = '{1, 4'd5,  2'b11, 16'h1111, 0, 4'd0,  16'h0000};
    tbl[4]  = '{1, 4'd5,  2'b11, 16'hAAAA, 1, 4'd5,  E_COL0};
    tbl[5]  = '{1, 4'd5,  2'b11, 16'h1111, 1, 4'd5,  E_COL1};
    tbl[6]  = '{1, 4'd5,  2'b01, 16'hAAAA, 1, 4'd5,  E_COL2};
    tbl[7]  = '{0, 4'd0,  2'b00, 16'h0000, 1, 4'd5,  16'h11AA};
    tbl[8]  = '{1, 4'd9,  2'b00, 16'h3456, 1, 4'd9,  16'h0000};
    tbl[9]  = '{0, 4'd0,  2'b00, 16'h0000, 1, 4'd9,  16'h0000};
    tbl[10] = '{1, 4'd10, 2'b01, 16'h7777, 1, 4'd3,  16'h12EF};
    tbl[11] = '{0, 4'd0,  2'b00, 16'h0000, 1, 4'd10, 16'h0077};

    #2;
    reset_dut();

    // Init with both ports busy: everything must be dropped
    for (int i = 0; i < 16; i++) do_cycle(1, 4'd2, 2'b11, 16'hFFFF, 1, 4'(i), 0, 0);
    for (int i = 0; i < 16; i++) do_cycle(0, 0, 0, 0, 1, 4'(i), 1, 16'h0000);

    for (int i = 0; i < 12; i++)
      do_cycle(tbl[i].we, tbl[i].wa, tbl[i].le, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].re, tbl[i].exp);
    idle(3);
    check("hold_data_lat1", rd_data1, 16'h0077);
    check("hold_data_lat2", rd_data2, 16'h0077);

    // Back-to-back reads of every address with writes elsewhere
    for (int i = 0; i < 16; i++) begin
      logic [3:0] wa;
      wa = 4'((i + 1 + int'($urandom_range(0, 14))) % 16);
      do_cycle(1'($urandom_range(0, 1)), wa, 2'($urandom_range(0, 3)), 16'($urandom),
               1, 4'(i), 0, 0);
    end
    idle(3);

    // Reset with a read in flight
    do_cycle(1, 4'd7, 2'b11, 16'h5555, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 4'd7, 0, 0);
    #2;
    reset_dut();
    idle(16);
    do_cycle(0, 0, 0, 0, 1, 4'd7, 1, 16'h0000);
    idle(4);

    check("q1_drained", 16'(q1.size()), 16'd0);
    check("q2_drained", 16'(q2.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
